buffer_copy_engine: RTL and testbench

//  Parametrised buffer-to-buffer transfer engine for the FHE ALU buffer RAMs.

---
 rtl/buffer_copy_engine_if.sv | 37 +++
 rtl/buffer_copy_engine.sv | 169 ++++++++++++++++
 tb/tb_buffer_copy_engine.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/buffer_copy_engine_if.sv
// Buffer copy engine port bundle: sequencer control
// plus source-read and destination-write RAM ports.
interface buffer_copy_engine_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
);
  logic              start;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] src_base;
  logic [ADDR_W-1:0] dst_base;
  logic [ADDR_W:0]   length;
  logic [DATA_W-1:0] fill_value;
  logic              abort;
  logic              busy;
  logic              done;
  logic              aborted;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport slave (
    input  start, mode, src_base, dst_base,
    input  length, fill_value, abort, rd_data,
    output busy, done, aborted,
    output rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport master (
    output start, mode, src_base, dst_base,
    output length, fill_value, abort, rd_data,
    input  busy, done, aborted,
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/buffer_copy_engine.sv
// Buffer-to-buffer transfer engine: streams a range from a
// source RAM to a destination RAM at one word per cycle.
module buffer_copy_engine #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 64,
  parameter int RD_LAT      = 2,
  parameter int EXTRA_DELAY = 0
) (
  input  logic clk,
  input  logic rstn,
  buffer_copy_engine_if.slave bus
);
  localparam int PIPE = RD_LAT + 1 + EXTRA_DELAY;
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   cnt;
  logic [DATA_W-1:0] fill_q;
  logic              fill_m;
  logic              zero_m;
  logic              rev_m;
  logic              busy_q;
  logic              done_q;
  logic              abt_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              wr_en_q;
  logic              wr_last;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              v_q    [PIPE];
  logic              last_q [PIPE];
  logic [ADDR_W-1:0] off_q  [PIPE];
  logic [DATA_W-1:0] src_d;

  function automatic logic [ADDR_W-1:0] bitrev(
    input logic [ADDR_W-1:0] a
  );
    logic [ADDR_W-1:0] r;
    for (int b = 0; b < ADDR_W; b++) r[b] = a[ADDR_W-1-b];
    return r;
  endfunction

  generate
    if (EXTRA_DELAY == 0) begin : g_nodly
      assign src_d = bus.rd_data;
    end else begin : g_dly
      logic [DATA_W-1:0] dq [EXTRA_DELAY];
      // Routing delay stages between read data and write port
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int k = 0; k < EXTRA_DELAY; k++) dq[k] <= '0;
        end else begin
          dq[0] <= bus.rd_data;
          for (int k = 1; k < EXTRA_DELAY; k++) dq[k] <= dq[k-1];
        end
      end
      assign src_d = dq[EXTRA_DELAY-1];
    end
  endgenerate

  // Control FSM, issue counter, item pipeline and write port
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      cnt       <= '0;
      fill_q    <= '0;
      fill_m    <= 1'b0;
      zero_m    <= 1'b0;
      rev_m     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      abt_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_last   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int k = 0; k < PIPE; k++) begin
        v_q[k]    <= 1'b0;
        last_q[k] <= 1'b0;
        off_q[k]  <= '0;
      end
    end else begin
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      v_q[0]    <= 1'b0;
      last_q[0] <= 1'b0;
      for (int k = 1; k < PIPE; k++) begin
        v_q[k]    <= v_q[k-1];
        last_q[k] <= last_q[k-1];
        off_q[k]  <= off_q[k-1];
      end
      wr_en_q   <= v_q[PIPE-1];
      wr_last   <= v_q[PIPE-1] & last_q[PIPE-1];
      wr_addr_q <= dst_q + (rev_m ? bitrev(off_q[PIPE-1])
                                  : off_q[PIPE-1]);
      wr_data_q <= zero_m ? '0 : (fill_m ? fill_q : src_d);
      unique case (state)
        IDLE: begin
          if (bus.start && !done_q) begin
            src_q  <= bus.src_base;
            dst_q  <= bus.dst_base;
            len_q  <= bus.length;
            fill_q <= bus.fill_value;
            fill_m <= bus.mode[0];
            zero_m <= (bus.mode == 2'b11);
            rev_m  <= (bus.mode == 2'b10);
            abt_q  <= 1'b0;
            if (bus.length == '0) begin
              done_q <= 1'b1;
            end else begin
              busy_q    <= 1'b1;
              rd_en_q   <= ~bus.mode[0];
              rd_addr_q <= bus.src_base;
              v_q[0]    <= 1'b1;
              off_q[0]  <= '0;
              last_q[0] <= (bus.length == ONE);
              cnt       <= ONE;
              state     <= (bus.length == ONE) ? DRAIN : ISSUE;
            end
          end
        end
        ISSUE, DRAIN: begin
          if (bus.abort) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            abt_q   <= 1'b1;
            wr_en_q <= 1'b0;
            wr_last <= 1'b0;
            for (int k = 0; k < PIPE; k++) v_q[k] <= 1'b0;
          end else if (state == ISSUE) begin
            rd_en_q   <= ~fill_m;
            rd_addr_q <= src_q + cnt[ADDR_W-1:0];
            v_q[0]    <= 1'b1;
            off_q[0]  <= cnt[ADDR_W-1:0];
            last_q[0] <= (cnt + ONE == len_q);
            cnt       <= cnt + ONE;
            if (cnt + ONE == len_q) state <= DRAIN;
          end else if (wr_en_q && wr_last) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.aborted = abt_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
endmodule

// File: tb/tb_buffer_copy_engine.sv
// Testbench for buffer_copy_engine: source RAM model,
// write monitor and a transfer-level reference model.
module tb_buffer_copy_engine;
  localparam int AW    = 10;
  localparam int DW    = 64;
  localparam int RL    = 2;
  localparam int XD    = 0;
  localparam int PIPE  = RL + 1 + XD;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   busy_n = 0;

  buffer_copy_engine_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  buffer_copy_engine #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .EXTRA_DELAY(XD)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_pipe [RL];

  always @(posedge clk) begin
    rd_pipe[0] <= mem[bus.rd_addr];
    for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign bus.rd_data = rd_pipe[RL-1];

  logic [AW-1:0] wa_q [$];
  logic [DW-1:0] wd_q [$];
  int            wc_q [$];
  logic [AW-1:0] ra_q [$];
  int            rc_q [$];
  int            dc_q [$];
  logic          da_q [$];
  logic [AW-1:0] ex_a [$];
  logic [DW-1:0] ex_d [$];
  int            ex_c [$];

  always @(negedge clk) begin
    if (bus.wr_en) begin
      wa_q.push_back(bus.wr_addr);
      wd_q.push_back(bus.wr_data);
      wc_q.push_back(cyc);
    end
    if (bus.rd_en) begin
      ra_q.push_back(bus.rd_addr);
      rc_q.push_back(cyc);
    end
    if (bus.done) begin
      dc_q.push_back(cyc);
      da_q.push_back(bus.aborted);
    end
    if (bus.busy) busy_n++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic int rev(input int v);
    int r;
    r = 0;
    for (int b = 0; b < AW; b++)
      if (((v >> b) & 1) != 0) r = r | (1 << (AW - 1 - b));
    return r;
  endfunction

  task automatic clear_q();
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    ra_q.delete(); rc_q.delete();
    dc_q.delete(); da_q.delete();
    busy_n = 0;
  endtask

  task automatic model(input logic [1:0] m, input int src,
                       input int dst, input int len,
                       input logic [DW-1:0] f, input int s);
    ex_a.delete(); ex_d.delete(); ex_c.delete();
    for (int i = 0; i < len; i++) begin
      int off;
      off = (m == 2'b10) ? rev(i) : i;
      ex_a.push_back(AW'((dst + off) % DEPTH));
      if (m == 2'b00 || m == 2'b10)
        ex_d.push_back(mem[(src + i) % DEPTH]);
      else if (m == 2'b01)
        ex_d.push_back(f);
      else
        ex_d.push_back(DW'(0));
      ex_c.push_back(s + 1 + i + PIPE);
    end
  endtask

  task automatic kick(input logic [1:0] m, input int src,
                      input int dst, input int len,
                      input logic [DW-1:0] f, output int s);
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.mode       = m;
    bus.src_base   = src[AW-1:0];
    bus.dst_base   = dst[AW-1:0];
    bus.length     = len[AW:0];
    bus.fill_value = f;
    s = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int n = 0; n < budget && dc_q.size() == 0; n++)
      @(posedge clk);
    repeat (3) @(posedge clk);
  endtask

  task automatic run(input logic [1:0] m, input int src,
                     input int dst, input int len,
                     input logic [DW-1:0] f, output int s);
    clear_q();
    kick(m, src, dst, len, f, s);
    wait_done(len + PIPE + 20);
    model(m, src, dst, len, f, s);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({bus.busy, bus.done, bus.aborted} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_status: got %b want 000",
               {bus.busy, bus.done, bus.aborted});
    end
    n_chk++;
    if ({bus.rd_en, bus.wr_en} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b want 00",
               {bus.rd_en, bus.wr_en});
    end
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({bus.busy, bus.done, bus.wr_en} !== 3'b000) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b want 000",
               {bus.busy, bus.done, bus.wr_en});
    end
  endtask

  task automatic test_copy_full();
    int s;
    run(2'b00, 0, 'h100, 1024, '0, s);
    n_chk++;
    if (wa_q.size() !== 1024) begin
      n_fail++;
      $display("FAIL copy_count: got %0d want 1024", wa_q.size());
    end
    for (int i = 0; i < ex_a.size() && i < wa_q.size(); i++) begin
      n_chk++;
      if (wa_q[i] !== ex_a[i] || wd_q[i] !== ex_d[i] ||
          wc_q[i] !== ex_c[i]) begin
        n_fail++;
        $display("FAIL copy_item[%0d]: got a=%h d=%h c=%0d want a=%h d=%h c=%0d",
                 i, wa_q[i], wd_q[i], wc_q[i], ex_a[i], ex_d[i], ex_c[i]);
      end
    end
    for (int i = 0; i < 1024 && i < ra_q.size(); i++) begin
      n_chk++;
      if (ra_q[i] !== AW'(i) || rc_q[i] !== s + 1 + i) begin
        n_fail++;
        $display("FAIL copy_read[%0d]: got a=%h c=%0d want a=%h c=%0d",
                 i, ra_q[i], rc_q[i], AW'(i), s + 1 + i);
      end
    end
    n_chk++;
    if (dc_q.size() !== 1 || dc_q[0] !== s + 1028) begin
      n_fail++;
      $display("FAIL copy_done: got n=%0d c=%0d want n=1 c=%0d",
               dc_q.size(), dc_q.size() > 0 ? dc_q[0] : -1, s + 1028);
    end
  endtask

  task automatic test_fill();
    int s;
    int want [5];
    want = '{'h3FE, 'h3FF, 'h000, 'h001, 'h002};
    run(2'b01, 'h2A, 'h3FE, 5, 64'hDEAD, s);
    n_chk++;
    if (wa_q.size() !== 5 || ra_q.size() !== 0) begin
      n_fail++;
      $display("FAIL fill_counts: got wr=%0d rd=%0d want wr=5 rd=0",
               wa_q.size(), ra_q.size());
    end
    for (int i = 0; i < 5 && i < wa_q.size(); i++) begin
      n_chk++;
      if (wa_q[i] !== AW'(want[i]) || wd_q[i] !== 64'hDEAD) begin
        n_fail++;
        $display("FAIL fill_item[%0d]: got a=%h d=%h want a=%h d=dead",
                 i, wa_q[i], wd_q[i], want[i]);
      end
    end
  endtask

  task automatic test_bitrev();
    int s;
    int src;
    int want [4];
    want = '{'h000, 'h200, 'h100, 'h300};
    src = $urandom_range(0, DEPTH - 1);
    run(2'b10, src, 0, 4, '0, s);
    n_chk++;
    if (wa_q.size() !== 4) begin
      n_fail++;
      $display("FAIL bitrev_count: got %0d want 4", wa_q.size());
    end
    for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
      n_chk++;
      if (wa_q[i] !== AW'(want[i]) ||
          wd_q[i] !== mem[(src + i) % DEPTH]) begin
        n_fail++;
        $display("FAIL bitrev_item[%0d]: got a=%h d=%h want a=%h d=%h",
                 i, wa_q[i], wd_q[i], want[i], mem[(src + i) % DEPTH]);
      end
    end
  endtask

  task automatic test_zero_len();
    int s;
    run(2'b00, 5, 9, 0, '0, s);
    n_chk++;
    if (dc_q.size() !== 1 || dc_q[0] !== s + 1) begin
      n_fail++;
      $display("FAIL zero_done: got n=%0d c=%0d want n=1 c=%0d",
               dc_q.size(), dc_q.size() > 0 ? dc_q[0] : -1, s + 1);
    end
    n_chk++;
    if (busy_n !== 0 || wa_q.size() !== 0 || ra_q.size() !== 0) begin
      n_fail++;
      $display("FAIL zero_quiet: got busy=%0d wr=%0d rd=%0d want 0 0 0",
               busy_n, wa_q.size(), ra_q.size());
    end
  endtask

  task automatic test_ignored_start();
    int s;
    int s2;
    int src;
    int dst;
    src = $urandom_range(0, DEPTH - 1);
    dst = $urandom_range(0, DEPTH - 1);
    clear_q();
    kick(2'b00, src, dst, 16, '0, s);
    repeat (3) @(posedge clk);
    kick(2'b01, 'h55, 'h77, 8, 64'hFFFF, s2);
    wait_done(60);
    model(2'b00, src, dst, 16, '0, s);
    n_chk++;
    if (wa_q.size() !== 16 || dc_q.size() !== 1) begin
      n_fail++;
      $display("FAIL ignored_counts: got wr=%0d done=%0d want 16 1",
               wa_q.size(), dc_q.size());
    end
    for (int i = 0; i < 16 && i < wa_q.size(); i++) begin
      n_chk++;
      if (wa_q[i] !== ex_a[i] || wd_q[i] !== ex_d[i]) begin
        n_fail++;
        $display("FAIL ignored_item[%0d]: got a=%h d=%h want a=%h d=%h",
                 i, wa_q[i], wd_q[i], ex_a[i], ex_d[i]);
      end
    end
  endtask

  task automatic test_abort();
    int s;
    int s2;
    clear_q();
    kick(2'b00, 'h10, 'h20, 64, '0, s);
    repeat (4) @(posedge clk);
    #1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({bus.busy, bus.done, bus.aborted} !== 3'b011) begin
      n_fail++;
      $display("FAIL abort_status: got %b want 011 at cyc %0d",
               {bus.busy, bus.done, bus.aborted}, cyc);
    end
    repeat (10) @(posedge clk);
    n_chk++;
    if (rc_q.size() !== 5 || rc_q[rc_q.size()-1] >= s + 6) begin
      n_fail++;
      $display("FAIL abort_reads: got n=%0d want n=5 all before %0d",
               rc_q.size(), s + 6);
    end
    n_chk++;
    if (wc_q.size() !== 2 || wc_q[wc_q.size()-1] >= s + 6) begin
      n_fail++;
      $display("FAIL abort_writes: got n=%0d want n=2 all before %0d",
               wc_q.size(), s + 6);
    end
    n_chk++;
    if (dc_q.size() !== 1 || dc_q[0] !== s + 6 || bus.aborted !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_done: got n=%0d held=%b want n=1 c=%0d held=1",
               dc_q.size(), bus.aborted, s + 6);
    end
    clear_q();
    kick(2'b00, 0, 0, 2, '0, s2);
    @(negedge clk);
    n_chk++;
    if (bus.aborted !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_clear: got aborted=%b busy=%b want 0 1",
               bus.aborted, bus.busy);
    end
    wait_done(30);
    clear_q();
    @(posedge clk); #1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    repeat (3) @(posedge clk);
    n_chk++;
    if (dc_q.size() !== 0 || bus.aborted !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_abort: got done=%0d aborted=%b want 0 0",
               dc_q.size(), bus.aborted);
    end
  endtask

  task automatic test_reset_mid();
    int s;
    clear_q();
    kick(2'b00, 'h33, 'h44, 64, '0, s);
    repeat (9) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    n_chk++;
    if ({bus.busy, bus.wr_en, bus.rd_en, bus.done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midreset_async: got %b want 0000",
               {bus.busy, bus.wr_en, bus.rd_en, bus.done});
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({bus.busy, bus.wr_en, bus.aborted} !== 3'b000) begin
      n_fail++;
      $display("FAIL midreset_idle: got %b want 000",
               {bus.busy, bus.wr_en, bus.aborted});
    end
    run(2'b00, 'h3F0, 'h3F8, 20, '0, s);
    n_chk++;
    if (wa_q.size() !== 20 || dc_q.size() !== 1 ||
        wa_q[19] !== ex_a[19] || wd_q[19] !== ex_d[19]) begin
      n_fail++;
      $display("FAIL midreset_restart: got wr=%0d done=%0d want 20 1",
               wa_q.size(), dc_q.size());
    end
  endtask

  task automatic test_random();
    int s;
    int len;
    int bad;
    int wdone;
    logic [1:0] m;
    for (int j = 0; j < 8; j++) begin
      m   = 2'($urandom_range(0, 3));
      len = (j == 0) ? 1 : $urandom_range(0, 40);
      run(m, $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
          len, {$urandom, $urandom}, s);
      bad = 0;
      for (int i = 0; i < ex_a.size() && i < wa_q.size(); i++)
        if (wa_q[i] !== ex_a[i] || wd_q[i] !== ex_d[i] ||
            wc_q[i] !== ex_c[i]) bad++;
      n_chk++;
      if (wa_q.size() !== len || bad !== 0) begin
        n_fail++;
        $display("FAIL rand%0d_writes: got n=%0d bad=%0d want n=%0d bad=0 mode=%0d",
                 j, wa_q.size(), bad, len, m);
      end
      wdone = (len == 0) ? s + 1 : s + len + PIPE + 1;
      n_chk++;
      if (dc_q.size() !== 1 || dc_q[0] !== wdone ||
          ra_q.size() !== (m[0] ? 0 : len)) begin
        n_fail++;
        $display("FAIL rand%0d_ctrl: got done=%0d c=%0d rd=%0d want 1 %0d %0d",
                 j, dc_q.size(), dc_q.size() > 0 ? dc_q[0] : -1,
                 ra_q.size(), wdone, m[0] ? 0 : len);
      end
    end
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.mode       = 2'b00;
    bus.src_base   = '0;
    bus.dst_base   = '0;
    bus.length     = '0;
    bus.fill_value = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
    test_reset();
    test_copy_full();
    test_fill();
    test_bitrev();
    test_zero_len();
    test_ignored_start();
    test_abort();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
